// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C target register bank.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_IDX,
    ST_WDATA,
    ST_RDATA
  } state_t;

  localparam logic [3:0] ACK_SLOT = 4'd8;

  function automatic logic [7:0] ptr_wrap(input logic [7:0] ptr, input int num_regs);
    if (int'({24'd0, ptr}) + 1 >= num_regs) return 8'd0;
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser and stability filter for one open-drain pad, with
// single-cycle rise/fall pulses of the filtered level.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic start_rst,
  input  logic i_raw,
  output logic o_filt,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_filt_d;
  logic [CW-1:0] r_cnt;

  // The filtered level only follows after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) begin
      r_sync   <= 2'b11;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync   <= {r_sync[0], i_raw};
      r_filt_d <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_filt & ~r_filt_d;
  assign o_fall = ~r_filt & r_filt_d;

endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target exposing NUM_REGS byte registers; all logic runs on clk with
// oversampled, filtered SCL/SDA.
//
// state    | meaning
// ST_IDLE  | not addressed, waiting for START
// ST_ADDR  | receiving address + R/W byte
// ST_IDX   | receiving register index
// ST_WDATA | receiving data bytes into reg[ptr]
// ST_RDATA | driving reg[ptr] to the master
module i2c_target_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h55,
  parameter int         NUM_REGS   = 4,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] RESET_VAL  = 8'h00
) (
  input  logic                  clk,
  input  logic                  start_rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb,
  output logic [7:0]            wr_idx,
  output logic                  busy
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic w_scl_f, w_scl_rise, w_scl_fall;
  logic w_sda_f, w_sda_rise, w_sda_fall;
  logic w_start, w_stop, w_byte_end, w_ack_end;
  logic w_addr_match, w_idx_ok;
  logic [7:0] w_ptr_inc, w_rd_cur, w_rd_inc;

  state_t r_state, w_state_nxt;

  logic [7:0] r_shift;
  logic [3:0] r_bitcnt;
  logic       r_armed;
  logic       r_rw;
  logic       r_mack;
  logic [7:0] r_rd;
  logic [7:0] r_ptr;
  logic       r_sda_oe;
  logic       r_wr_stb;
  logic [7:0] r_wr_idx;
  logic       r_busy;
  logic [7:0] r_regs [NUM_REGS];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .start_rst(start_rst), .i_raw(scl_i),
    .o_filt(w_scl_f), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .start_rst(start_rst), .i_raw(sda_i),
    .o_filt(w_sda_f), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start      = w_sda_fall & w_scl_f;
  assign w_stop       = w_sda_rise & w_scl_f;
  assign w_byte_end   = w_scl_fall & ~w_start & ~w_stop & r_armed & (r_bitcnt == ACK_SLOT - 4'd1);
  assign w_ack_end    = w_scl_fall & ~w_start & ~w_stop & r_armed & (r_bitcnt == ACK_SLOT);
  assign w_addr_match = (r_shift[7:1] == DEV_ADDR);
  assign w_idx_ok     = ({24'd0, r_shift} < 32'(NUM_REGS));
  assign w_ptr_inc    = ptr_wrap(r_ptr, NUM_REGS);
  assign w_rd_cur     = r_regs[r_ptr[IW-1:0]];
  assign w_rd_inc     = r_regs[w_ptr_inc[IW-1:0]];

  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_byte_end) begin
      case (r_state)
        ST_ADDR: if (!w_addr_match) w_state_nxt = ST_IDLE;
        ST_IDX:  if (!w_idx_ok)     w_state_nxt = ST_IDLE;
        default: ;
      endcase
    end else if (w_ack_end) begin
      case (r_state)
        ST_ADDR:  w_state_nxt = r_rw ? ST_RDATA : ST_IDX;
        ST_IDX:   w_state_nxt = ST_WDATA;
        ST_RDATA: if (!r_mack) w_state_nxt = ST_IDLE;
        default: ;
      endcase
    end
  end

  // The first SCL fall after a START only arms the bit counter; it ends the START, not a bit.
  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_armed  <= 1'b0;
      r_rw     <= 1'b0;
      r_mack   <= 1'b0;
      r_rd     <= '0;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_idx <= '0;
      r_busy   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_start || w_stop) begin
        r_bitcnt <= '0;
        r_armed  <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else if (w_scl_rise) begin
        if (r_bitcnt == ACK_SLOT) r_mack  <= ~w_sda_f;
        else                      r_shift <= {r_shift[6:0], w_sda_f};
      end else if (w_scl_fall) begin
        r_sda_oe <= 1'b0;
        if (!r_armed) begin
          r_armed <= 1'b1;
        end else if (r_bitcnt == ACK_SLOT - 4'd1) begin
          r_bitcnt <= ACK_SLOT;
          case (r_state)
            ST_ADDR: begin
              r_sda_oe <= w_addr_match;
              r_rw     <= r_shift[0];
              if (w_addr_match) r_busy <= 1'b1;
            end
            ST_IDX: begin
              r_sda_oe <= w_idx_ok;
              if (w_idx_ok) r_ptr <= r_shift;
            end
            ST_WDATA: r_sda_oe <= 1'b1;
            default: ;
          endcase
        end else if (r_bitcnt == ACK_SLOT) begin
          r_bitcnt <= '0;
          case (r_state)
            ST_ADDR: if (r_rw) begin
              r_rd     <= w_rd_cur;
              r_sda_oe <= ~w_rd_cur[7];
            end
            ST_WDATA: begin
              r_regs[r_ptr[IW-1:0]] <= r_shift;
              r_wr_stb <= 1'b1;
              r_wr_idx <= r_ptr;
              r_ptr    <= w_ptr_inc;
            end
            ST_RDATA: if (r_mack) begin
              r_ptr    <= w_ptr_inc;
              r_rd     <= w_rd_inc;
              r_sda_oe <= ~w_rd_inc[7];
            end
            default: ;
          endcase
        end else begin
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_state == ST_RDATA) begin
            r_rd     <= {r_rd[6:0], 1'b0};
            r_sda_oe <= ~r_rd[6];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = r_regs[g];
  end

  assign sda_oe = r_sda_oe;
  assign wr_stb = r_wr_stb;
  assign wr_idx = r_wr_idx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_i2c_target_regbank.sv
// Bus-level bench: a bit-banged I2C master drives the target; acks, read data
// and write strobes are checked against a byte-level register model.
module tb_i2c_target_regbank;

  localparam logic [6:0] DEV = 7'h55;
  localparam int         NR  = 4;
  localparam int         FL  = 3;
  localparam logic [7:0] RV  = 8'h3C;
  localparam int         Q   = 8;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic start_rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_i;
  logic sda_oe, wr_stb, busy;
  logic [8*NR-1:0] regs_o;
  logic [7:0] wr_idx;

  assign sda_i = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target_regbank #(.DEV_ADDR(DEV), .NUM_REGS(NR), .FILTER_LEN(FL), .RESET_VAL(RV)) dut (
    .clk(clk), .start_rst(start_rst), .scl_i(m_scl), .sda_i(sda_i),
    .sda_oe(sda_oe), .regs_o(regs_o), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]  mdl_regs [NR];
  int          mdl_ptr;
  logic [15:0] exp_rsp[$];
  logic [15:0] obs_rsp[$];
  logic [15:0] exp_wr[$];
  logic [15:0] e_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ack_tok(input logic a);
    return {8'h01, 7'd0, a};
  endfunction

  function automatic logic [15:0] data_tok(input logic [7:0] d);
    return {8'h02, d};
  endfunction

  function automatic logic [8*NR-1:0] mdl_flat();
    logic [8*NR-1:0] r;
    for (int k = 0; k < NR; k++) r[8*k +: 8] = mdl_regs[k];
    return r;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < NR; k++) mdl_regs[k] = RV;
    mdl_ptr = 0;
  endtask

  // response scoreboard: master-observed acks/bytes against model expectations
  initial begin : rsp_checker
    logic [15:0] o, e;
    forever begin
      @(negedge clk);
      while (obs_rsp.size() > 0) begin
        o = obs_rsp.pop_front();
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp: unexpected observation 0x%0h", o);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp", 32'(o), 32'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_stb: unexpected pulse idx=%0d", wr_idx);
      end else begin
        e_wr = exp_wr.pop_front();
        chk("wr_idx", 32'(wr_idx), 32'(e_wr[15:8]));
        chk("wr_data", 32'(regs_o[8*wr_idx +: 8]), 32'(e_wr[7:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    m_sda = b;
    if (glitch) begin
      wq(Q/2); m_scl = 1'b1; wq(1); m_scl = 1'b0; wq(Q - Q/2 - 1);
    end else begin
      wq(Q);
    end
    m_scl = 1'b1; wq(2*Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    b = sda_i;    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic nak;
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(nak);
    ack = ~nak;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~mack, 1'b0);
  endtask

  task automatic xfer_write(input logic [6:0] a, input logic [7:0] idx, input bq_t data, input bit do_stop);
    logic ack;
    bit ok;
    bus_start();
    ok = (a == DEV);
    exp_rsp.push_back(ack_tok(ok));
    send_byte({a, 1'b0}, -1, ack);
    obs_rsp.push_back(ack_tok(ack));
    if (ok) begin
      ok = (idx < NR);
      exp_rsp.push_back(ack_tok(ok));
      send_byte(idx, -1, ack);
      obs_rsp.push_back(ack_tok(ack));
      if (ok) begin
        mdl_ptr = int'(idx);
        foreach (data[j]) begin
          exp_rsp.push_back(ack_tok(1'b1));
          exp_wr.push_back({8'(mdl_ptr), data[j]});
          mdl_regs[mdl_ptr] = data[j];
          mdl_ptr = (mdl_ptr + 1) % NR;
          send_byte(data[j], -1, ack);
          obs_rsp.push_back(ack_tok(ack));
        end
      end
    end
    if (do_stop || !ok) bus_stop();
  endtask

  task automatic xfer_read(input logic [6:0] a, input int n);
    logic ack, mack;
    logic [7:0] d;
    bit ok;
    bus_start();
    ok = (a == DEV);
    exp_rsp.push_back(ack_tok(ok));
    send_byte({a, 1'b1}, -1, ack);
    obs_rsp.push_back(ack_tok(ack));
    if (ok) begin
      chk("busy_active", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
        mack = (i < n - 1);
        exp_rsp.push_back(data_tok(mdl_regs[mdl_ptr]));
        if (mack) mdl_ptr = (mdl_ptr + 1) % NR;
        recv_byte(mack, d);
        obs_rsp.push_back(data_tok(d));
      end
      chk("sda_released", 32'(sda_oe), 32'd0);
    end
    bus_stop();
  endtask

  task automatic post_check();
    wq(4);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sda_oe_idle", 32'(sda_oe), 32'd0);
    chk("regs", regs_o, mdl_flat());
  endtask

  initial begin
    bq_t d;
    logic ack, b;
    int kind, n;
    logic [6:0] a;
    logic [7:0] idx;

    mdl_reset();
    wq(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_regs", regs_o, mdl_flat());
    start_rst = 1'b0;
    wq(10);

    d.delete(); d.push_back(8'h57);
    xfer_write(DEV, 8'd3, d, 1'b1);
    post_check();

    d.delete(); d.push_back(8'h11); d.push_back(8'h22); d.push_back(8'h33);
    xfer_write(DEV, 8'd2, d, 1'b1);
    post_check();

    d.delete();
    xfer_write(DEV, 8'd1, d, 1'b0);
    xfer_read(DEV, 2);
    post_check();

    d.delete(); d.push_back(8'hFF);
    xfer_write(7'h54, 8'd0, d, 1'b1);
    post_check();
    xfer_write(DEV, 8'd9, d, 1'b1);
    post_check();

    // SCL glitch inside a byte, then STOP after a partial byte
    bus_start();
    exp_rsp.push_back(ack_tok(1'b1));
    send_byte({DEV, 1'b0}, -1, ack); obs_rsp.push_back(ack_tok(ack));
    exp_rsp.push_back(ack_tok(1'b1));
    send_byte(8'h00, -1, ack); obs_rsp.push_back(ack_tok(ack));
    mdl_ptr = 0;
    exp_rsp.push_back(ack_tok(1'b1));
    exp_wr.push_back({8'd0, 8'h96});
    mdl_regs[0] = 8'h96;
    mdl_ptr = 1;
    send_byte(8'h96, 3, ack); obs_rsp.push_back(ack_tok(ack));
    put_bit(1'b1, 1'b0); put_bit(1'b0, 1'b1); put_bit(1'b1, 1'b0); put_bit(1'b1, 1'b0);
    bus_stop();
    post_check();

    // reset in the middle of a read byte
    d.delete(); d.push_back(8'h0F);
    xfer_write(DEV, 8'd2, d, 1'b1);
    d.delete();
    xfer_write(DEV, 8'd2, d, 1'b0);
    bus_start();
    exp_rsp.push_back(ack_tok(1'b1));
    send_byte({DEV, 1'b1}, -1, ack); obs_rsp.push_back(ack_tok(ack));
    get_bit(b); chk("rd_bit7", 32'(b), 32'd0);
    get_bit(b); chk("rd_bit6", 32'(b), 32'd0);
    chk("oe_driving", 32'(sda_oe), 32'd1);
    start_rst = 1'b1;
    #1;
    chk("oe_async_drop", 32'(sda_oe), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    wq(3);
    start_rst = 1'b0;
    mdl_reset();
    wq(10);
    post_check();
    d.delete(); d.push_back(8'hA5); d.push_back(8'h5A);
    xfer_write(DEV, 8'd1, d, 1'b1);
    d.delete();
    xfer_write(DEV, 8'd0, d, 1'b0);
    xfer_read(DEV, 3);
    post_check();

    for (int it = 0; it < 20; it++) begin
      kind = int'($urandom_range(0, 2));
      a = ($urandom_range(0, 5) == 0) ? (DEV ^ 7'($urandom_range(1, 127))) : DEV;
      d.delete();
      if (kind == 0) begin
        idx = 8'($urandom_range(0, 5));
        n = int'($urandom_range(0, 4));
        for (int j = 0; j < n; j++) d.push_back(8'($urandom));
        xfer_write(a, idx, d, 1'b1);
      end else if (kind == 1) begin
        idx = 8'($urandom_range(0, NR - 1));
        xfer_write(DEV, idx, d, 1'b0);
        xfer_read(a, int'($urandom_range(1, 4)));
      end else begin
        xfer_read(a, int'($urandom_range(1, 4)));
      end
      post_check();
    end

    wq(20);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'd0);
    chk("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regbank.md
# i2c_target_regbank

Parametrised I2C target (slave) exposing a bank of NUM_REGS byte registers to an external master; successor of the fixed 4-register, SCL-clocked slave. All logic runs on the system clock: SCL/SDA are synchronised, glitch-filtered and edge-detected. New capabilities:
- register auto-increment with wrap-around
- out-of-range index NACK
- repeated-START handling
- a write-strobe interface to core logic

## Interface
Parameters:
- DEV_ADDR, 7'h55, 7-bit target address
- NUM_REGS, 4, register count, 1..256
- FILTER_LEN, 3, consecutive identical samples before a filtered line changes, ≥1
- RESET_VAL, 8'h00, reset value of every register

Ports:
- clk  in  1  system clock; f_clk ≥ 20 × f_SCL
- start_rst  in  1  reset start_rst, asynchronous, active-high
- scl_i  in  1  raw SCL pad input
- sda_i  in  1  raw SDA pad input
- sda_oe  out  1  1 = pull SDA low (open drain); reset 0
- regs_o  out  8*NUM_REGS  flat register bank, reg k at [8k+7:8k]; reset RESET_VAL each
- wr_stb  out  1  one-cycle pulse when a register is written; reset 0
- wr_idx  out  8  index written, valid with wr_stb; reset 0
- busy  out  1  high between an addressed START and the following STOP; reset 0

## Operation
- **Line conditioning:** 2-FF synchroniser per line, then a FILTER_LEN-deep stability filter giving scl_f/sda_f; filter outputs reset to 1. Edge detectors produce scl_rise and scl_fall. START = sda_f falls while scl_f=1; STOP = sda_f rises while scl_f=1.
- **Shift/count:** sda_f is sampled into an 8-bit shift register on scl_rise. A 4-bit counter 0..8 advances on scl_fall; count 8 is the ACK slot. A START clears the counter.
- **State machine:** IDLE, ADDR, IDX, WDATA, RDATA.
  - IDLE: START → ADDR.
  - ADDR, 8th bit: address match + R/W=0 → ACK, then IDX; match + R/W=1 → ACK, then RDATA; mismatch → no ACK, IDLE.
  - IDX: value < NUM_REGS → ACK, ptr ← value, then WDATA; value ≥ NUM_REGS → NACK, ptr unchanged, IDLE.
  - WDATA: each byte is ACKed and written to reg[ptr]; wr_stb pulses with wr_idx=ptr; ptr ← ptr+1, wrapping NUM_REGS-1 → 0.
  - RDATA: drive reg[ptr] MSB first. On master ACK (sda_f=0 at the 9th scl_rise), ptr ← ptr+1 (wrapped) and continue. On NACK, release SDA and go to IDLE.
- **Interrupting conditions:** START in any state → ADDR; this is a repeated START, busy stays high. STOP in any state → IDLE and busy falls. A partial byte is discarded: no write, no ptr change.
- **Pointer retention:** ptr is retained across STOP and repeated START; reset value 0. A master may therefore read from the last-written location without re-sending an index.
- **Read data source:** the read data byte is captured from reg[ptr] at the ACK-slot scl_fall that precedes it, so a write during the read does not tear the byte.

## Timing
- Input latency: 2 sync cycles + FILTER_LEN cycles + 1 edge-detect cycle from pad to scl_rise/scl_fall/START/STOP.
- sda_oe changes only in the cycle after a detected scl_fall, never while scl_f=1, so START/STOP are never falsely generated by the target.
- ACK is driven from the scl_fall ending bit 8 to the scl_fall ending the ACK slot.
- regs_o updates one cycle after the ACK-slot scl_fall of a write byte; wr_stb is asserted in that same cycle.
- START and STOP take priority over a coincident scl edge event.
- start_rst mid-transfer: sda_oe drops to 0 asynchronously; all state, ptr and regs return to reset values. After release the block waits in IDLE for a START.

## Structure
- Shared package i2c_pkg: state enum (IDLE, ADDR, IDX, WDATA, RDATA), ACK_SLOT=4'd8 constant, and a helper function for ptr increment with wrap.
- Sub-module i2c_line_filter (synchroniser + stability filter + rise/fall outputs), instantiated once for SCL and once for SDA.
- Top-level block: FSM, shifter, counter, pointer, register bank, output driver.

## Test plan
- Write 0xAA, 0x03, 0x57, STOP → reg3=0x57; one wr_stb with wr_idx=3; ACK on all three bytes.
- With NUM_REGS=4: write 0xAA, 0x02, 0x11, 0x22, 0x33 → reg2=0x11, reg3=0x22, reg0=0x33 (wrap); three wr_stb pulses.
- Write 0xAA, 0x01, repeated START, 0xAB, read two bytes (ACK then NACK), STOP → returns reg1 then reg2; SDA released after NACK.
- Address 0xA8 or index 0x09 (NUM_REGS=4) → NACK (sda_oe stays 0 in the ACK slot); no register changes; FSM in IDLE.
- 1-cycle SCL glitch with FILTER_LEN=3, plus STOP after 4 data bits → no extra bit counted; partial byte not written; busy falls.
- Assert start_rst in the middle of a read byte → sda_oe=0 immediately; regs_o=RESET_VAL; the next full transaction behaves normally.
